// File: rtl/sample_seq_pkg.sv
// Shared types and helpers for the FFT sample index sequencers.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sample_seq_pkg;

    localparam int DEFAULT_MAX_LOG2 = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_e;

    // A zero or oversized frame length request falls back to the largest frame.
    function automatic int clamp_len(input int len_log2, input int max_log2);
        if (len_log2 == 0 || len_log2 > max_log2) begin
            return max_log2;
        end
        return len_log2;
    endfunction

endpackage

// File: rtl/idx_bit_reverse.sv
// Reverses the low len_log2 bits of an index; bits above len_log2 read as 0.
// Latency: purely combinational.
// Backpressure: none; len_log2 must not exceed IDX_W (callers clamp it).
module idx_bit_reverse #(
    parameter int IDX_W = 5,
    parameter int LEN_W = $clog2(IDX_W + 1)
) (
    input  logic [IDX_W-1:0] value,
    input  logic [LEN_W-1:0] len_log2,
    output logic [IDX_W-1:0] result
);

    logic [IDX_W-1:0] masked;
    logic [IDX_W-1:0] rev_full;
    logic [LEN_W-1:0] shamt;

    // Mirror the whole word, then shift down so only the low len_log2 bits survive.
    always_comb begin
        masked   = value & ~({IDX_W{1'b1}} << len_log2);
        rev_full = '0;
        for (int i = 0; i < IDX_W; i++) begin
            rev_full[i] = masked[IDX_W-1-i];
        end
        shamt  = LEN_W'(IDX_W) - len_log2;
        result = rev_full >> shamt;
    end

endmodule

// File: rtl/sample_out_sequencer.sv
// Emits the read index for each FFT result frame, natural or bit-reversed order.
// Latency: first index one cycle after accepted start; done/aborted one cycle after frame end.
// Backpressure: index and last hold while out_valid & !out_ready; abort ends a frame regardless.
module sample_out_sequencer
    import sample_seq_pkg::*;
#(
    parameter  int MAX_LOG2 = DEFAULT_MAX_LOG2,
    parameter  int IDX_W    = MAX_LOG2,
    parameter  int CNT_W    = MAX_LOG2 + 1,
    localparam int LEN_W    = $clog2(MAX_LOG2 + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len_log2,
    input  logic             bitrev_en,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] samples_out_count
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             bitrev_q, bitrev_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [IDX_W-1:0] len_mask;
    logic [IDX_W-1:0] rev_idx;
    logic             is_run;
    logic             is_last;
    logic             hs;

    idx_bit_reverse #(
        .IDX_W (IDX_W),
        .LEN_W (LEN_W)
    ) u_rev (
        .value    (cnt_q),
        .len_log2 (len_q),
        .result   (rev_idx)
    );

    // Decode frame position and the handshake from registered state only.
    always_comb begin
        is_run   = (state_q == RUN);
        len_mask = ~({IDX_W{1'b1}} << len_q);
        is_last  = (cnt_q == len_mask);
        hs       = is_run & out_ready;
    end

    // Next-state logic: abort outranks the last beat, and a beat taken alongside abort still counts.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        bitrev_d = bitrev_q;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = LEN_W'(clamp_len(int'(len_log2), MAX_LOG2));
                    bitrev_d = bitrev_en;
                    cnt_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    cnt_d   = cnt_q + IDX_W'(1);
                    count_d = count_q + CNT_W'(1);
                end
                if (abort) begin
                    state_d = ABORT;
                end else if (hs && is_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and frame registers; reset drops straight to IDLE with no completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            bitrev_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            bitrev_q <= bitrev_d;
            count_q  <= count_d;
        end
    end

    // Outputs are pure decodes of registers, so no input reaches an output in the same cycle.
    always_comb begin
        out_valid         = is_run;
        busy              = is_run;
        done              = (state_q == DONE);
        aborted           = (state_q == ABORT);
        out_last          = is_run & is_last;
        out_index         = is_run ? (bitrev_q ? rev_idx : cnt_q) : '0;
        samples_out_count = count_q;
    end

endmodule

// File: tb/tb_sample_out_sequencer.sv
// Self-checking bench: expected index/last pairs are queued when a frame is requested
// and popped on every observed handshake.
module tb_sample_out_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] len_log2;
    logic       bitrev_en;
    logic       abort;
    logic       out_ready;
    logic       out_valid;
    logic [4:0] out_index;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [5:0] samples_out_count;

    typedef struct {
        int idx;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bit   b_vld;
    bit   b_hs;
    int   b_idx;
    bit   b_last;

    always #5 clk = ~clk;

    sample_out_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .len_log2          (len_log2),
        .bitrev_en         (bitrev_en),
        .abort             (abort),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_index         (out_index),
        .out_last          (out_last),
        .busy              (busy),
        .done              (done),
        .aborted           (aborted),
        .samples_out_count (samples_out_count)
    );

    // Called at a negedge: drive ready, capture what the coming edge will transfer.
    task automatic beat(input bit rdy);
        out_ready = rdy;
        b_vld     = out_valid;
        b_hs      = out_valid && rdy;
        b_idx     = int'(out_index);
        b_last    = out_last;
        @(negedge clk);
    endtask

    task automatic start_frame(input int len, input bit br);
        start     = 1'b1;
        len_log2  = len[2:0];
        bitrev_en = br;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic push_natural(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.idx  = i;
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; len_log2 = '0; bitrev_en = 1'b0;
        abort = 1'b0; out_ready = 1'b0;
        #12;
        checks++;
        if ({out_valid, out_index, out_last, busy, done, aborted, samples_out_count} !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {out_valid, out_index, out_last, busy, done, aborted, samples_out_count});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_natural();
        exp_t e;
        int   n = 0;
        int   cyc = 0;
        bit   got_last = 0;
        push_natural(32);
        start_frame(5, 1'b0);
        checks++;
        if (busy !== 1'b1 || samples_out_count !== 6'd0) begin
            errors++;
            $display("FAIL nat_start: got busy=%0b count=%0d expected busy=1 count=0", busy, samples_out_count);
        end
        while (!got_last && cyc < 100) begin
            beat(1'b1);
            cyc++;
            if (b_hs) begin
                n++;
                e = exp_q.pop_front();
                checks++;
                if (b_idx !== e.idx || b_last !== e.last) begin
                    errors++;
                    $display("FAIL nat_idx: got idx=%0d last=%0b expected idx=%0d last=%0b", b_idx, b_last, e.idx, e.last);
                end
                if (b_last) got_last = 1;
            end
        end
        checks++;
        if (cyc !== 32 || n !== 32) begin
            errors++;
            $display("FAIL nat_beats: got cycles=%0d handshakes=%0d expected 32/32", cyc, n);
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL nat_done: got done=%0b valid=%0b expected done=1 valid=0", done, out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || samples_out_count !== 6'd32) begin
            errors++;
            $display("FAIL nat_idle: got done=%0b busy=%0b count=%0d expected 0/0/32", done, busy, samples_out_count);
        end
    endtask

    task automatic test_bitrev();
        int   tbl[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        exp_t e;
        int   n = 0;
        int   cyc = 0;
        bit   got_last = 0;
        for (int i = 0; i < 8; i++) begin
            e.idx  = tbl[i];
            e.last = (i == 7);
            exp_q.push_back(e);
        end
        start_frame(3, 1'b1);
        while (!got_last && cyc < 40) begin
            beat(1'b1);
            cyc++;
            if (b_hs) begin
                n++;
                e = exp_q.pop_front();
                checks++;
                if (b_idx !== e.idx || b_last !== e.last) begin
                    errors++;
                    $display("FAIL rev_idx: got idx=%0d last=%0b expected idx=%0d last=%0b", b_idx, b_last, e.idx, e.last);
                end
                if (b_last) got_last = 1;
            end
        end
        checks++;
        if (n !== 8 || done !== 1'b1 || samples_out_count !== 6'd8) begin
            errors++;
            $display("FAIL rev_end: got hs=%0d done=%0b count=%0d expected 8/1/8", n, done, samples_out_count);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        exp_t e;
        int   n = 0;
        int   k = 0;
        int   prev_idx = -1;
        bit   prev_stall = 0;
        bit   got_last = 0;
        push_natural(4);
        start_frame(2, 1'b0);
        while (!got_last && k < 40) begin
            beat(k % 3 == 0);
            if (b_vld && prev_stall) begin
                checks++;
                if (b_idx !== prev_idx) begin
                    errors++;
                    $display("FAIL stall_hold: got idx=%0d expected idx=%0d", b_idx, prev_idx);
                end
            end
            prev_stall = b_vld && !b_hs;
            prev_idx   = b_idx;
            if (b_hs) begin
                n++;
                e = exp_q.pop_front();
                checks++;
                if (b_idx !== e.idx || b_last !== e.last) begin
                    errors++;
                    $display("FAIL stall_idx: got idx=%0d last=%0b expected idx=%0d last=%0b", b_idx, b_last, e.idx, e.last);
                end
                if (b_last) got_last = 1;
            end
            if (n < 4) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_early_done: got done=%0b expected 0 after %0d handshakes", done, n);
                end
            end
            k++;
        end
        checks++;
        if (n !== 4 || done !== 1'b1 || samples_out_count !== 6'd4) begin
            errors++;
            $display("FAIL stall_end: got hs=%0d done=%0b count=%0d expected 4/1/4", n, done, samples_out_count);
        end
        @(negedge clk);
    endtask

    task automatic test_abort_mid();
        exp_t e;
        push_natural(32);
        start_frame(5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            beat(1'b1);
            e = exp_q.pop_front();
            checks++;
            if (!b_hs || b_idx !== e.idx) begin
                errors++;
                $display("FAIL abort_mid_idx: got hs=%0b idx=%0d expected hs=1 idx=%0d", b_hs, b_idx, e.idx);
            end
        end
        abort = 1'b1;
        beat(1'b0);
        abort = 1'b0;
        checks++;
        if (aborted !== 1'b1 || done !== 1'b0 || samples_out_count !== 6'd10) begin
            errors++;
            $display("FAIL abort_mid: got aborted=%0b done=%0b count=%0d expected 1/0/10", aborted, done, samples_out_count);
        end
        @(negedge clk);
        checks++;
        if (aborted !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || samples_out_count !== 6'd10) begin
            errors++;
            $display("FAIL abort_mid_idle: got aborted=%0b busy=%0b done=%0b count=%0d expected 0/0/0/10",
                     aborted, busy, done, samples_out_count);
        end
        exp_q.delete();
    endtask

    task automatic test_abort_last();
        exp_t e;
        push_natural(32);
        start_frame(5, 1'b0);
        for (int i = 0; i < 32; i++) begin
            if (i == 31) abort = 1'b1;
            beat(1'b1);
            e = exp_q.pop_front();
            checks++;
            if (!b_hs || b_idx !== e.idx || b_last !== e.last) begin
                errors++;
                $display("FAIL abort_last_idx: got hs=%0b idx=%0d last=%0b expected hs=1 idx=%0d last=%0b",
                         b_hs, b_idx, b_last, e.idx, e.last);
            end
        end
        abort = 1'b0;
        checks++;
        if (aborted !== 1'b1 || done !== 1'b0 || samples_out_count !== 6'd32) begin
            errors++;
            $display("FAIL abort_last: got aborted=%0b done=%0b count=%0d expected 1/0/32", aborted, done, samples_out_count);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_last_nodone: got done=%0b busy=%0b expected 0/0", done, busy);
        end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   n = 0;
        int   cyc = 0;
        bit   got_last = 0;
        push_natural(4);
        start_frame(2, 1'b0);
        start    = 1'b1;
        len_log2 = 3'd5;
        while (!got_last && cyc < 20) begin
            beat(1'b1);
            cyc++;
            if (b_hs) begin
                e = exp_q.pop_front();
                checks++;
                if (b_idx !== e.idx || b_last !== e.last) begin
                    errors++;
                    $display("FAIL ign_idx: got idx=%0d last=%0b expected idx=%0d last=%0b", b_idx, b_last, e.idx, e.last);
                end
                if (b_last) got_last = 1;
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ign_done: got done=%0b expected 1", done);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || samples_out_count !== 6'd4) begin
            errors++;
            $display("FAIL ign_idle: got busy=%0b valid=%0b count=%0d expected 0/0/4", busy, out_valid, samples_out_count);
        end
        // Oversized length request runs the largest frame.
        push_natural(32);
        start_frame(7, 1'b0);
        got_last = 0;
        cyc = 0;
        while (!got_last && cyc < 100) begin
            beat(1'b1);
            cyc++;
            if (b_hs) begin
                n++;
                e = exp_q.pop_front();
                checks++;
                if (b_idx !== e.idx || b_last !== e.last) begin
                    errors++;
                    $display("FAIL clamp_idx: got idx=%0d last=%0b expected idx=%0d last=%0b", b_idx, b_last, e.idx, e.last);
                end
                if (b_last) got_last = 1;
            end
        end
        checks++;
        if (n !== 32 || samples_out_count !== 6'd32) begin
            errors++;
            $display("FAIL clamp_len: got hs=%0d count=%0d expected 32/32", n, samples_out_count);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc = 0;
        bit   got_last = 0;
        push_natural(32);
        start_frame(5, 1'b0);
        for (int i = 0; i < 12; i++) begin
            beat(1'b1);
            e = exp_q.pop_front();
            checks++;
            if (!b_hs || b_idx !== e.idx) begin
                errors++;
                $display("FAIL rst_mid_idx: got hs=%0b idx=%0d expected hs=1 idx=%0d", b_hs, b_idx, e.idx);
            end
        end
        exp_q.delete();
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_index, out_last, busy, done, aborted, samples_out_count} !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got %b expected all zero",
                     {out_valid, out_index, out_last, busy, done, aborted, samples_out_count});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_pulse: got done=%0b aborted=%0b busy=%0b expected 0/0/0", done, aborted, busy);
            end
        end
        // Two-sample bit-reversed frame: reversal of one bit is the identity.
        push_natural(2);
        start_frame(1, 1'b1);
        while (!got_last && cyc < 20) begin
            beat(1'b1);
            cyc++;
            if (b_hs) begin
                e = exp_q.pop_front();
                checks++;
                if (b_idx !== e.idx || b_last !== e.last) begin
                    errors++;
                    $display("FAIL rst_after_idx: got idx=%0d last=%0b expected idx=%0d last=%0b", b_idx, b_last, e.idx, e.last);
                end
                if (b_last) got_last = 1;
            end
        end
        checks++;
        if (cyc !== 2 || done !== 1'b1 || samples_out_count !== 6'd2) begin
            errors++;
            $display("FAIL rst_after_end: got cycles=%0d done=%0b count=%0d expected 2/1/2", cyc, done, samples_out_count);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_natural();
        test_bitrev();
        test_stall();
        test_abort_mid();
        test_abort_last();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
